connect_n_game_ctrl: RTL and testbench

Parametrised game-logic core for the Connect-N family. It generalises the fixed 7x6 connect-four game to any board size and win length. It conditions the three raw buttons, owns the cursor and board state, and runs a sequential win/draw check after each drop. The VGA renderer reads the board through a combinational cell-read port; the TinyTapeout top wrapper connects the buttons and the renderer.

---
 rtl/connect_n_pkg.sv | 52 +++++
 rtl/connect_n_game_ctrl_button_conditioner.sv | 41 ++++
 rtl/connect_n_game_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_connect_n_game_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/connect_n_pkg.sv
// Shared types and step deltas for the Connect-N game core.
package connect_n_pkg;

  typedef enum logic [1:0] {
    GS_PLAY  = 2'd0,
    GS_CHECK = 2'd1,
    GS_WIN   = 2'd2,
    GS_DRAW  = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    DIR_H  = 2'd0,
    DIR_V  = 2'd1,
    DIR_D1 = 2'd2,
    DIR_D2 = 2'd3
  } dir_t;

  // D1 rises to the right (/), D2 falls to the right (\)
  localparam logic signed [1:0] DX_H  = 2'sd1;
  localparam logic signed [1:0] DY_H  = 2'sd0;
  localparam logic signed [1:0] DX_V  = 2'sd0;
  localparam logic signed [1:0] DY_V  = 2'sd1;
  localparam logic signed [1:0] DX_D1 = 2'sd1;
  localparam logic signed [1:0] DY_D1 = 2'sd1;
  localparam logic signed [1:0] DX_D2 = 2'sd1;
  localparam logic signed [1:0] DY_D2 = -2'sd1;

  function automatic logic signed [1:0] dir_dx(input logic [1:0] d);
    case (d)
      DIR_H:   return DX_H;
      DIR_V:   return DX_V;
      DIR_D1:  return DX_D1;
      default: return DX_D2;
    endcase
  endfunction

  function automatic logic signed [1:0] dir_dy(input logic [1:0] d);
    case (d)
      DIR_H:   return DY_H;
      DIR_V:   return DY_V;
      DIR_D1:  return DY_D1;
      default: return DY_D2;
    endcase
  endfunction

endpackage

// File: rtl/connect_n_game_ctrl_button_conditioner.sv
// Raw button -> two-flop sync -> debounced level -> one-cycle rising-edge pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_25MHz,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_pulse
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic             r_level_q;
  logic [CNT_W-1:0] r_cnt;

  // Down-counter reloads whenever the input agrees with the level; terminal count flips the level
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b00;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= CNT_LOAD;
    end else begin
      r_sync    <= {r_sync[0], i_raw};
      r_level_q <= r_level;
      if (r_sync[1] == r_level) begin
        r_cnt <= CNT_LOAD;
      end else if (r_cnt == '0) begin
        r_level <= r_sync[1];
        r_cnt   <= CNT_LOAD;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_pulse = r_level & ~r_level_q;

endmodule

// File: rtl/connect_n_game_ctrl.sv
// Connect-N game core: buttons, cursor, board, and a one-cell-per-cycle win/draw scan.
// state | meaning
// PLAY  | accepting moves and drops
// CHECK | scanning the four lines through the placed piece
// WIN   | terminal, winner latched; drop restarts
// DRAW  | terminal, board full; drop restarts
module connect_n_game_ctrl
  import connect_n_pkg::*;
#(
  parameter int COLS            = 7,
  parameter int ROWS            = 6,
  parameter int WIN_LEN         = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                      clk_25MHz,
  input  logic                      rst_n,
  input  logic                      move_right,
  input  logic                      move_left,
  input  logic                      drop_piece,
  input  logic [$clog2(COLS)-1:0]   rd_col,
  input  logic [$clog2(ROWS)-1:0]   rd_row,
  output logic [1:0]                rd_cell,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic                      cur_player,
  output logic [1:0]                game_state,
  output logic [1:0]                winner,
  output logic                      busy
);
  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int HW   = $clog2(ROWS + 1);
  localparam int PCW  = $clog2(COLS * ROWS + 1);
  localparam int RUNW = $clog2(2 * WIN_LEN);
  localparam int SW   = (WIN_LEN > 2) ? $clog2(WIN_LEN - 1) : 1;
  localparam int AW   = ((CW > RW) ? CW : RW) + 2;

  localparam logic [1:0]             S_PLAY    = GS_PLAY;
  localparam logic [1:0]             S_CHECK   = GS_CHECK;
  localparam logic [1:0]             S_WIN     = GS_WIN;
  localparam logic [1:0]             S_DRAW    = GS_DRAW;
  localparam logic signed [AW-1:0]   COLS_A    = AW'(COLS);
  localparam logic signed [AW-1:0]   ROWS_A    = AW'(ROWS);
  localparam logic [CW:0]            COLS_RD   = (CW + 1)'(COLS);
  localparam logic [RW:0]            ROWS_RD   = (RW + 1)'(ROWS);
  localparam logic [CW-1:0]          CUR_MAX   = CW'(COLS - 1);
  localparam logic [HW-1:0]          ROWS_H    = HW'(ROWS);
  localparam logic [PCW-1:0]         FULL      = PCW'(COLS * ROWS);
  localparam logic [RUNW-1:0]        RUN_ONE   = RUNW'(1);
  localparam logic [RUNW-1:0]        WIN_A     = RUNW'(WIN_LEN);
  localparam logic [SW-1:0]          STEP_LAST = SW'(WIN_LEN - 2);

  logic [1:0]           r_board [COLS][ROWS];
  logic [HW-1:0]        r_height [COLS];
  logic [PCW-1:0]       r_count;
  logic [CW-1:0]        r_cursor, r_px;
  logic [RW-1:0]        r_py;
  logic signed [AW-1:0] r_cx, r_cy;
  logic [1:0]           r_dir;
  logic                 r_side;
  logic [SW-1:0]        r_step;
  logic [RUNW-1:0]      r_run;
  logic                 r_player;
  logic [1:0]           r_state, r_winner;

  logic                 w_right, w_left, w_drop;
  logic signed [1:0]    w_dx2, w_dy2;
  logic signed [AW-1:0] w_dx, w_dy, w_nx, w_ny;
  logic                 w_in, w_match, w_side_done, w_col_open;
  logic [1:0]           w_player_cell;
  logic [RUNW-1:0]      w_run_nx;
  logic [HW-1:0]        w_cur_height;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_right (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .i_raw(move_right), .o_pulse(w_right));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_left (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .i_raw(move_left), .o_pulse(w_left));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_drop (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .i_raw(drop_piece), .o_pulse(w_drop));

  // Next probe is one step from the last matched cell, outward on the current side
  assign w_dx2         = dir_dx(r_dir);
  assign w_dy2         = dir_dy(r_dir);
  assign w_dx          = {{(AW-2){w_dx2[1]}}, w_dx2};
  assign w_dy          = {{(AW-2){w_dy2[1]}}, w_dy2};
  assign w_nx          = r_side ? (r_cx - w_dx) : (r_cx + w_dx);
  assign w_ny          = r_side ? (r_cy - w_dy) : (r_cy + w_dy);
  assign w_in          = !w_nx[AW-1] && (w_nx < COLS_A) && !w_ny[AW-1] && (w_ny < ROWS_A);
  assign w_player_cell = r_player ? CELL_P2 : CELL_P1;
  assign w_match       = w_in && (r_board[w_nx[CW-1:0]][w_ny[RW-1:0]] == w_player_cell);
  assign w_side_done   = !w_match || (r_step == STEP_LAST);
  assign w_run_nx      = r_run + {{(RUNW-1){1'b0}}, w_match};
  assign w_cur_height  = r_height[r_cursor];
  assign w_col_open    = w_cur_height < ROWS_H;

  always_comb begin
    rd_cell = CELL_EMPTY;
    if (({1'b0, rd_col} < COLS_RD) && ({1'b0, rd_row} < ROWS_RD))
      rd_cell = r_board[rd_col][rd_row];
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < COLS; c++) begin
        r_height[c] <= '0;
        for (int r = 0; r < ROWS; r++) r_board[c][r] <= CELL_EMPTY;
      end
      r_count  <= '0;
      r_cursor <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_dir    <= DIR_H;
      r_side   <= 1'b0;
      r_step   <= '0;
      r_run    <= RUN_ONE;
      r_player <= 1'b0;
      r_state  <= S_PLAY;
      r_winner <= CELL_EMPTY;
    end else begin
      case (r_state)
        S_PLAY: begin
          if (w_drop) begin
            if (w_col_open) begin
              r_board[r_cursor][w_cur_height[RW-1:0]] <= w_player_cell;
              r_height[r_cursor] <= w_cur_height + 1'b1;
              r_count  <= r_count + 1'b1;
              r_px     <= r_cursor;
              r_py     <= w_cur_height[RW-1:0];
              r_cx     <= AW'(r_cursor);
              r_cy     <= AW'(w_cur_height);
              r_dir    <= DIR_H;
              r_side   <= 1'b0;
              r_step   <= '0;
              r_run    <= RUN_ONE;
              r_state  <= S_CHECK;
            end
          end else if (w_right && !w_left) begin
            r_cursor <= (r_cursor == CUR_MAX) ? '0 : r_cursor + 1'b1;
          end else if (w_left && !w_right) begin
            r_cursor <= (r_cursor == '0) ? CUR_MAX : r_cursor - 1'b1;
          end
        end
        S_CHECK: begin
          if (w_match) begin
            r_run  <= w_run_nx;
            r_cx   <= w_nx;
            r_cy   <= w_ny;
            r_step <= r_step + 1'b1;
          end
          if (w_side_done) begin
            r_step <= '0;
            r_cx   <= AW'(r_px);
            r_cy   <= AW'(r_py);
            if (!r_side) begin
              r_side <= 1'b1;
            end else begin
              r_side <= 1'b0;
              r_run  <= RUN_ONE;
              if (w_run_nx >= WIN_A) begin
                r_state  <= S_WIN;
                r_winner <= w_player_cell;
              end else if (r_dir == DIR_D2) begin
                if (r_count == FULL) begin
                  r_state <= S_DRAW;
                end else begin
                  r_player <= ~r_player;
                  r_state  <= S_PLAY;
                end
              end else begin
                r_dir <= r_dir + 2'd1;
              end
            end
          end
        end
        default: begin
          if (w_drop) begin
            for (int c = 0; c < COLS; c++) begin
              r_height[c] <= '0;
              for (int r = 0; r < ROWS; r++) r_board[c][r] <= CELL_EMPTY;
            end
            r_count  <= '0;
            r_cursor <= '0;
            r_player <= 1'b0;
            r_winner <= CELL_EMPTY;
            r_state  <= S_PLAY;
          end
        end
      endcase
    end
  end

  assign cursor_col = r_cursor;
  assign cur_player = r_player;
  assign game_state = r_state;
  assign winner     = r_winner;
  assign busy       = (r_state == S_CHECK);

endmodule

// File: tb/tb_connect_n_game_ctrl.sv
// Bench for connect_n_game_ctrl: a 7x6 board and a 3x3 board, short debounce.
module tb_connect_n_game_ctrl;

  localparam int OP_L = 0;
  localparam int OP_R = 1;
  localparam int OP_D = 2;
  localparam int OP_G = 3;
  localparam int MAX_BUSY = 28;

  typedef struct {
    int dut;
    int op;
    int cur;
    int ply;
    int st;
    int win;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_right, a_left, a_drop;
  logic [2:0] a_rd_col, a_rd_row, a_cursor;
  logic [1:0] a_rd_cell, a_state, a_winner;
  logic       a_player, a_busy;

  logic       b_rst_n, b_right, b_left, b_drop;
  logic [1:0] b_rd_col, b_rd_row, b_cursor;
  logic [1:0] b_rd_cell, b_state, b_winner;
  logic       b_player, b_busy;

  connect_n_game_ctrl #(.COLS(7), .ROWS(6), .WIN_LEN(4), .DEBOUNCE_CYCLES(4)) u_dut_a (
    .clk_25MHz(clk), .rst_n(a_rst_n), .move_right(a_right), .move_left(a_left),
    .drop_piece(a_drop), .rd_col(a_rd_col), .rd_row(a_rd_row), .rd_cell(a_rd_cell),
    .cursor_col(a_cursor), .cur_player(a_player), .game_state(a_state),
    .winner(a_winner), .busy(a_busy));

  connect_n_game_ctrl #(.COLS(3), .ROWS(3), .WIN_LEN(4), .DEBOUNCE_CYCLES(4)) u_dut_b (
    .clk_25MHz(clk), .rst_n(b_rst_n), .move_right(b_right), .move_left(b_left),
    .drop_piece(b_drop), .rd_col(b_rd_col), .rd_row(b_rd_row), .rd_cell(b_rd_cell),
    .cursor_col(b_cursor), .cur_player(b_player), .game_state(b_state),
    .winner(b_winner), .busy(b_busy));

  int    n_checks = 0;
  int    n_errors = 0;
  int    last_busy = 0;
  int    vec_idx = 0;
  step_t vecs[$];
  step_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int get_cur(input int dut);
    return (dut == 0) ? int'(a_cursor) : int'(b_cursor);
  endfunction
  function automatic int get_ply(input int dut);
    return (dut == 0) ? int'(a_player) : int'(b_player);
  endfunction
  function automatic int get_st(input int dut);
    return (dut == 0) ? int'(a_state) : int'(b_state);
  endfunction
  function automatic int get_win(input int dut);
    return (dut == 0) ? int'(a_winner) : int'(b_winner);
  endfunction
  function automatic int get_busy(input int dut);
    return (dut == 0) ? int'(a_busy) : int'(b_busy);
  endfunction

  task automatic set_btn(input int dut, input int op, input logic v);
    if (dut == 0) begin
      if (op == OP_L) a_left = v;
      else if (op == OP_D) a_drop = v;
      else a_right = v;
    end else begin
      if (op == OP_L) b_left = v;
      else if (op == OP_D) b_drop = v;
      else b_right = v;
    end
  endtask

  // Press, release and let the release debounce and any scan finish; counts busy cycles
  task automatic do_op(input int dut, input int op);
    int hold;
    hold = (op == OP_G) ? 3 : 8;
    last_busy = 0;
    set_btn(dut, op, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (get_busy(dut) != 0) last_busy++;
    end
    set_btn(dut, op, 1'b0);
    for (int i = 0; i < 52; i++) begin
      @(negedge clk);
      if (get_busy(dut) != 0) last_busy++;
    end
  endtask

  task automatic add(input int dut, input int op, input int c, input int p, input int s, input int w);
    step_t e;
    e.dut = dut; e.op = op; e.cur = c; e.ply = p; e.st = s; e.win = w;
    vecs.push_back(e);
  endtask

  task automatic run_vecs();
    step_t e;
    step_t g;
    while (vecs.size() > 0) begin
      e = vecs.pop_front();
      sb.push_back(e);
      do_op(e.dut, e.op);
      g = sb.pop_front();
      chk($sformatf("v%0d_cursor", vec_idx), get_cur(g.dut), g.cur);
      chk($sformatf("v%0d_player", vec_idx), get_ply(g.dut), g.ply);
      chk($sformatf("v%0d_state", vec_idx), get_st(g.dut), g.st);
      chk($sformatf("v%0d_winner", vec_idx), get_win(g.dut), g.win);
      chk($sformatf("v%0d_busy_idle", vec_idx), get_busy(g.dut), 0);
      if (g.op == OP_D)
        chk($sformatf("v%0d_busy_len_le_%0d", vec_idx, MAX_BUSY), int'(last_busy <= MAX_BUSY), 1);
      vec_idx++;
    end
  endtask

  task automatic chk_cell(input int dut, input int c, input int r, input int exp);
    if (dut == 0) begin
      a_rd_col = 3'(c); a_rd_row = 3'(r);
      #1 chk($sformatf("a_cell_%0d_%0d", c, r), int'(a_rd_cell), exp);
    end else begin
      b_rd_col = 2'(c); b_rd_row = 2'(r);
      #1 chk($sformatf("b_cell_%0d_%0d", c, r), int'(b_rd_cell), exp);
    end
  endtask

  task automatic check_empty(input int dut, input string name);
    int bad;
    bad = 0;
    if (dut == 0) begin
      for (int c = 0; c < 8; c++)
        for (int r = 0; r < 8; r++) begin
          a_rd_col = 3'(c); a_rd_row = 3'(r);
          #1 if (a_rd_cell != 2'b00) bad++;
        end
    end else begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          b_rd_col = 2'(c); b_rd_row = 2'(r);
          #1 if (b_rd_cell != 2'b00) bad++;
        end
    end
    chk(name, bad, 0);
  endtask

  task automatic chk_idle(input int dut, input string tag);
    chk({tag, "_cursor"}, get_cur(dut), 0);
    chk({tag, "_player"}, get_ply(dut), 0);
    chk({tag, "_state"}, get_st(dut), 0);
    chk({tag, "_winner"}, get_win(dut), 0);
    chk({tag, "_busy"}, get_busy(dut), 0);
  endtask

  task automatic reset_dut(input int dut);
    if (dut == 0) a_rst_n = 1'b0; else b_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    if (dut == 0) a_rst_n = 1'b1; else b_rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    a_rst_n = 1'b0; a_right = 1'b0; a_left = 1'b0; a_drop = 1'b0;
    a_rd_col = '0; a_rd_row = '0;
    b_rst_n = 1'b0; b_right = 1'b0; b_left = 1'b0; b_drop = 1'b0;
    b_rd_col = '0; b_rd_row = '0;
    repeat (3) @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state on both boards
    chk_idle(0, "rst_a");
    check_empty(0, "rst_a_empty");
    chk_idle(1, "rst_b");
    check_empty(1, "rst_b_empty");
    @(negedge clk);

    // Cursor wrap both ways and a glitch shorter than the debounce window
    add(0, OP_L, 6, 0, 0, 0);
    add(0, OP_R, 0, 0, 0, 0);
    add(0, OP_R, 1, 0, 0, 0);
    add(0, OP_G, 1, 0, 0, 0);
    // P1 stacks col0, P2 stacks col1, P1 wins vertically
    add(0, OP_L, 0, 0, 0, 0);
    add(0, OP_D, 0, 1, 0, 0);
    add(0, OP_R, 1, 1, 0, 0);
    add(0, OP_D, 1, 0, 0, 0);
    add(0, OP_L, 0, 0, 0, 0);
    add(0, OP_D, 0, 1, 0, 0);
    add(0, OP_R, 1, 1, 0, 0);
    add(0, OP_D, 1, 0, 0, 0);
    add(0, OP_L, 0, 0, 0, 0);
    add(0, OP_D, 0, 1, 0, 0);
    add(0, OP_R, 1, 1, 0, 0);
    add(0, OP_D, 1, 0, 0, 0);
    add(0, OP_L, 0, 0, 0, 0);
    add(0, OP_D, 0, 0, 2, 1);
    add(0, OP_R, 0, 0, 2, 1);
    add(0, OP_L, 0, 0, 2, 1);
    run_vecs();
    chk_cell(0, 0, 3, 1);
    chk_cell(0, 0, 0, 1);
    chk_cell(0, 1, 2, 2);
    chk_cell(0, 1, 3, 0);
    @(negedge clk);

    // Drop from WIN restarts the game
    add(0, OP_D, 0, 0, 0, 0);
    run_vecs();
    check_empty(0, "restart_after_win_empty");
    @(negedge clk);

    // Fill col3 with alternating players, then a drop into the full column
    add(0, OP_R, 1, 0, 0, 0);
    add(0, OP_R, 2, 0, 0, 0);
    add(0, OP_R, 3, 0, 0, 0);
    add(0, OP_D, 3, 1, 0, 0);
    add(0, OP_D, 3, 0, 0, 0);
    add(0, OP_D, 3, 1, 0, 0);
    add(0, OP_D, 3, 0, 0, 0);
    add(0, OP_D, 3, 1, 0, 0);
    add(0, OP_D, 3, 0, 0, 0);
    run_vecs();
    do_op(0, OP_D);
    chk("full_col_state", get_st(0), 0);
    chk("full_col_player", get_ply(0), 0);
    chk("full_col_no_check", last_busy, 0);
    chk_cell(0, 3, 0, 1);
    chk_cell(0, 3, 4, 1);
    chk_cell(0, 3, 5, 2);
    @(negedge clk);

    // Rising diagonal for P2 at (1,0)(2,1)(3,2)(4,3)
    reset_dut(0);
    add(0, OP_D, 0, 1, 0, 0);
    add(0, OP_R, 1, 1, 0, 0);
    add(0, OP_D, 1, 0, 0, 0);
    add(0, OP_R, 2, 0, 0, 0);
    add(0, OP_D, 2, 1, 0, 0);
    add(0, OP_D, 2, 0, 0, 0);
    add(0, OP_R, 3, 0, 0, 0);
    add(0, OP_D, 3, 1, 0, 0);
    add(0, OP_R, 4, 1, 0, 0);
    add(0, OP_D, 4, 0, 0, 0);
    add(0, OP_L, 3, 0, 0, 0);
    add(0, OP_D, 3, 1, 0, 0);
    add(0, OP_D, 3, 0, 0, 0);
    add(0, OP_R, 4, 0, 0, 0);
    add(0, OP_D, 4, 1, 0, 0);
    add(0, OP_R, 5, 1, 0, 0);
    add(0, OP_D, 5, 0, 0, 0);
    add(0, OP_L, 4, 0, 0, 0);
    add(0, OP_D, 4, 1, 0, 0);
    add(0, OP_D, 4, 1, 2, 2);
    run_vecs();
    chk("diag_busy_seen", int'(last_busy > 0), 1);
    chk_cell(0, 4, 3, 2);
    chk_cell(0, 1, 0, 2);
    chk_cell(0, 4, 2, 1);
    @(negedge clk);
    add(0, OP_D, 0, 0, 0, 0);
    run_vecs();
    check_empty(0, "restart_after_diag_empty");
    @(negedge clk);

    // 3x3 board with WIN_LEN 4 can only end in a draw
    add(1, OP_D, 0, 1, 0, 0);
    add(1, OP_D, 0, 0, 0, 0);
    add(1, OP_D, 0, 1, 0, 0);
    add(1, OP_R, 1, 1, 0, 0);
    add(1, OP_D, 1, 0, 0, 0);
    add(1, OP_D, 1, 1, 0, 0);
    add(1, OP_D, 1, 0, 0, 0);
    add(1, OP_R, 2, 0, 0, 0);
    add(1, OP_D, 2, 1, 0, 0);
    add(1, OP_D, 2, 0, 0, 0);
    add(1, OP_D, 2, 0, 3, 0);
    add(1, OP_L, 2, 0, 3, 0);
    run_vecs();
    chk_cell(1, 0, 0, 1);
    chk_cell(1, 2, 1, 2);
    chk_cell(1, 2, 2, 1);
    chk_cell(1, 3, 0, 0);
    chk_cell(1, 0, 3, 0);
    @(negedge clk);

    // Asynchronous reset while the scan is running
    reset_dut(1);
    b_drop = 1'b1;
    waited = 0;
    while (b_busy == 1'b0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("midcheck_busy_seen", int'(b_busy), 1);
    b_rst_n = 1'b0;
    #1;
    chk_idle(1, "midcheck_rst");
    check_empty(1, "midcheck_rst_empty");
    b_drop = 1'b0;
    @(negedge clk);
    @(negedge clk);
    b_rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk_idle(1, "after_midcheck");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
